// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259-style priority / in-service stage.
package pic_pkg;

  localparam int         PIC_NUM_IR     = 8;
  localparam logic [2:0] PIC_SPUR_LEVEL = 3'd7;

  typedef logic [2:0] level_t;

  typedef enum logic [1:0] {
    IDLE,
    ACK1,
    ACK2
  } state_t;

  // 0 = highest priority under the current rotation.
  function automatic level_t prio_rank(input level_t lvl, input level_t lowest);
    return lvl - lowest - 3'd1;
  endfunction

  function automatic logic [7:0] level_onehot(input level_t lvl);
    return 8'b1 << lvl;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating-priority encoder: returns the highest-priority set bit of req,
// where priority starts at lowest_prio+1 and wraps mod 8.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] req,
  input  level_t     lowest_prio,
  output logic       found,
  output level_t     level
);

  level_t idx;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    found = 1'b0;
    level = '0;
    idx   = '0;
    for (int i = PIC_NUM_IR; i >= 1; i--) begin
      idx = lowest_prio + 3'(i);
      if (req[idx]) begin
        found = 1'b1;
        level = idx;
      end
    end
  end

endmodule

// File: rtl/pic_priority_isr.sv
// Priority resolution, INT generation, two-pulse INTA sequencing, ISR and
// EOI handling for an 8259-compatible interrupt controller.
//
//   state | meaning
//   IDLE  | INT follows the valid winner; first INTA latches the level
//   ACK1  | waiting for the second INTA; IRR frozen
//   ACK2  | vector driven last cycle; release freeze next cycle
module pic_priority_isr
  import pic_pkg::*;
#(
  parameter int         NUM_IR     = PIC_NUM_IR,
  parameter logic [2:0] SPUR_LEVEL = PIC_SPUR_LEVEL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IR-1:0] irr,
  input  logic              inta,
  input  logic [4:0]        vector_base,
  input  logic              aeoi_mode,
  input  logic              rotate_on_aeoi,
  input  logic              eoi_cmd,
  input  logic              eoi_specific,
  input  logic              eoi_rotate,
  input  logic [2:0]        eoi_level,
  output logic              int_req,
  output logic              freeze,
  output logic [NUM_IR-1:0] clear_interrupt_request,
  output logic [NUM_IR-1:0] isr,
  output logic [7:0]        data_out,
  output logic              data_out_en
);

  state_t      state, state_next;
  level_t      lowest_prio, lowest_next;
  level_t      level_q, level_next;
  logic        spurious_q, spurious_next;

  logic        irr_found, isr_found;
  level_t      irr_level, isr_level;
  logic        winner_valid;

  logic        int_req_next, dout_en_next;
  logic [7:0]  clr_next, set_mask, aeoi_clr, eoi_clr, isr_next, data_next;
  logic        aeoi_rot, eoi_rot;
  level_t      eoi_rot_level;

  pic_priority_resolver u_irr_res (
    .req         (irr),
    .lowest_prio (lowest_prio),
    .found       (irr_found),
    .level       (irr_level)
  );

  pic_priority_resolver u_isr_res (
    .req         (isr),
    .lowest_prio (lowest_prio),
    .found       (isr_found),
    .level       (isr_level)
  );

  // Fully nested: a request must strictly outrank everything in service.
  assign winner_valid = irr_found &&
                        (!isr_found ||
                         (prio_rank(irr_level, lowest_prio) < prio_rank(isr_level, lowest_prio)));

  assign freeze = (state != IDLE);

  always_comb begin
    state_next    = state;
    int_req_next  = 1'b0;
    clr_next      = '0;
    set_mask      = '0;
    aeoi_clr      = '0;
    aeoi_rot      = 1'b0;
    dout_en_next  = 1'b0;
    level_next    = level_q;
    spurious_next = spurious_q;
    case (state)
      IDLE: begin
        int_req_next = winner_valid;
        if (inta) begin
          state_next    = ACK1;
          int_req_next  = 1'b0;
          spurious_next = !winner_valid;
          level_next    = winner_valid ? irr_level : SPUR_LEVEL;
          if (winner_valid) begin
            set_mask = level_onehot(irr_level);
            clr_next = set_mask;
          end
        end
      end
      ACK1: begin
        if (inta) begin
          state_next   = ACK2;
          dout_en_next = 1'b1;
          if (aeoi_mode && !spurious_q) begin
            aeoi_clr = level_onehot(level_q);
            aeoi_rot = rotate_on_aeoi;
          end
        end
      end
      ACK2:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    eoi_clr       = '0;
    eoi_rot       = 1'b0;
    eoi_rot_level = isr_level;
    if (eoi_cmd) begin
      if (eoi_specific) begin
        eoi_clr       = level_onehot(eoi_level);
        eoi_rot       = eoi_rotate;
        eoi_rot_level = eoi_level;
      end else if (isr_found) begin
        eoi_clr = level_onehot(isr_level);
        eoi_rot = eoi_rotate;
      end
    end
    // A set on the same bit as a clear wins.
    isr_next    = (isr & ~(eoi_clr | aeoi_clr)) | set_mask;
    lowest_next = eoi_rot ? eoi_rot_level : (aeoi_rot ? level_q : lowest_prio);
    data_next   = dout_en_next ? {vector_base, level_q} : data_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                   <= IDLE;
      lowest_prio             <= 3'd7;
      level_q                 <= '0;
      spurious_q              <= 1'b0;
      int_req                 <= 1'b0;
      clear_interrupt_request <= '0;
      isr                     <= '0;
      data_out                <= '0;
      data_out_en             <= 1'b0;
    end else begin
      state                   <= state_next;
      lowest_prio             <= lowest_next;
      level_q                 <= level_next;
      spurious_q              <= spurious_next;
      int_req                 <= int_req_next;
      clear_interrupt_request <= clr_next;
      isr                     <= isr_next;
      data_out                <= data_next;
      data_out_en             <= dout_en_next;
    end
  end

endmodule
